// File: rtl/lfsr_chk_pkg.sv
// Shared types and the PRBS step rule for the 8-bit Fibonacci LFSR checker.
// Latency: none (types and combinational helper only).
// Backpressure: not applicable.
package lfsr_chk_pkg;

    // Hunt/lock FSM states
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Feedback taps of the generator: bits 7, 5, 4 and 2
    localparam logic [7:0] TAPS = 8'b1011_0100;

    // One generator step: shift left, feedback is the XOR of the tapped bits
    function automatic logic [7:0] lfsr8_next(input logic [7:0] w);
        return {w[6:0], ^(w & TAPS)};
    endfunction

endpackage

// File: rtl/lfsr_chk_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Latency: count visible 1 clk after the enable/clear cycle.
// Backpressure: none; holds at all-ones once saturated.
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear first, otherwise increment unless already at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/lfsr_chk.sv
// PRBS-8 checker: hunts for lock on the generator sequence, then counts errored words.
// Latency: all outputs registered, visible 1 clk after the sampling strobe.
// Backpressure: none; every strobe is consumed, back-to-back strobes at full rate.
// Optional LFSR_CHK_STUCK_EN builds the all-zero lockup detector on 'stuck'.
module lfsr_chk
    import lfsr_chk_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strb,
    input  logic [7:0]       din,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic             stuck
);

    localparam logic [3:0] LOCK_RUN = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_RUN = 4'(LOSS_CNT);

    state_e     state_q, state_d;
    logic [7:0] ref_q, ref_d;
    logic       have_ref_q, have_ref_d;
    logic [3:0] run_q, run_d;
    logic       err_pulse_q, err_pulse_d;

    logic [7:0] exp_w;
    logic       match;
    logic [3:0] run_inc;
    logic       err_inc;

    // Hunt/lock decisions; state only moves on strobe cycles
    always_comb begin
        state_d     = state_q;
        ref_d       = ref_q;
        have_ref_d  = have_ref_q;
        run_d       = run_q;
        err_pulse_d = 1'b0;
        err_inc     = 1'b0;
        exp_w       = lfsr8_next(ref_q);
        match       = (din == exp_w);
        run_inc     = run_q + 4'd1;

        if (strb) begin
            if (!have_ref_q) begin
                // First word after reset only seeds the predictor
                ref_d      = din;
                have_ref_d = 1'b1;
            end else if (state_q == HUNT) begin
                // Re-seed from every received word so hunting self-synchronises
                ref_d = din;
                if (match) begin
                    if (run_inc == LOCK_RUN) begin
                        state_d = LOCKED;
                        run_d   = 4'd0;
                    end else begin
                        run_d = run_inc;
                    end
                end else begin
                    run_d = 4'd0;
                end
            end else begin
                // Free-running predictor: a bad word must not corrupt the model
                ref_d = exp_w;
                if (match) begin
                    run_d = 4'd0;
                end else begin
                    err_pulse_d = 1'b1;
                    err_inc     = 1'b1;
                    if (run_inc == LOSS_RUN) begin
                        state_d = HUNT;
                        run_d   = 4'd0;
                        ref_d   = din;
                    end else begin
                        run_d = run_inc;
                    end
                end
            end
        end
    end

    // FSM, predictor and pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            ref_q       <= 8'h00;
            have_ref_q  <= 1'b0;
            run_q       <= 4'd0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            have_ref_q  <= have_ref_d;
            run_q       <= run_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    sat_cnt #(
        .W   (CNT_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (err_clr),
        .en  (err_inc),
        .cnt (err_cnt)
    );

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;

`ifdef LFSR_CHK_STUCK_EN
    logic stuck_q, stuck_d;

    // Sticky all-zero detector; err_clr releases it
    always_comb begin
        stuck_d = stuck_q;
        if (err_clr) begin
            stuck_d = 1'b0;
        end else if (strb && (din == 8'h00)) begin
            stuck_d = 1'b1;
        end
    end

    // Lockup flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            stuck_q <= 1'b0;
        end else begin
            stuck_q <= stuck_d;
        end
    end

    assign stuck = stuck_q;
`else
    assign stuck = 1'b0;
`endif

endmodule
